// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART receive path.
//   parity_t   : frame parity mode (none / even / odd)
//   rx_state_t : receiver FSM states, also exported on the debug port
//   parity_error() : parity check of a received frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // data_xor is the XOR of all data bits. With even parity the ones count
  // including the parity bit must be even (total XOR 0); with odd parity the
  // total XOR must be 1.
  function automatic logic parity_error(input logic data_xor, input logic sample,
                                        input parity_t mode);
    return (data_xor ^ sample) != (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts sample_tick strobes within one bit period and flags the sample points.
//   clock, reset : system clock, asynchronous active-high reset
//   sample_tick  : strobe at OVERSAMPLE x baud; the counter only moves on ticks
//   restart      : on a tick, force the count back to 0
//   mid_pulse    : tick on which the count is OVERSAMPLE/2-1 (middle of start bit)
//   bit_pulse    : tick on which the count is OVERSAMPLE-1 (one full bit later)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_tick,
  input  logic restart,
  output logic mid_pulse,
  output logic bit_pulse
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (sample_tick) begin
      if (restart || (tick_cnt_q == BIT_LAST)) tick_cnt_d = '0;
      else                                     tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  assign mid_pulse = sample_tick && (tick_cnt_q == MID_LAST);
  assign bit_pulse = sample_tick && (tick_cnt_q == BIT_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
// UART receive path: 2-flop synchroniser, start detection, mid-bit sampling,
// LSB-first deserialisation and a one-entry output buffer with error flags.
//   clock, reset  : system clock, asynchronous active-high reset
//   sample_tick   : 1-cycle strobe at OVERSAMPLE x baud
//   rx            : serial line, idle high, asynchronous to clock
//   data          : buffered word, LSB = first data bit on the wire
//   data_valid    : buffer holds an unconsumed frame
//   data_ready    : consumer accepts
//   parity_err    : parity mismatch of the buffered frame
//   framing_err   : a stop bit of the buffered frame sampled 0
//   overrun_err   : 1-cycle pulse, a completed frame was dropped
//   busy          : FSM not idle
//   state_dbg     : current FSM state
//
// Handshake: a frame is transferred on every clock edge where data_valid and
// data_ready are both 1. data_valid stays high until that transfer; data and
// the flags are stable while data_valid is high and hold afterwards until the
// next frame is loaded. A frame completing on the same cycle as a transfer
// refills the buffer directly.
// -----------------------------------------------------------------------------
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter parity_t     PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy,
  output rx_state_t            state_dbg
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  // Synchroniser resets to the idle level so a line held low through reset
  // is not mistaken for a start bit.
  logic rx_meta_q, rx_sync_q;
  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_flag_q, par_flag_d;
  logic                 frame_acc_q, frame_acc_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_err_q, overrun_err_d;

  logic restart, mid_pulse, bit_pulse, frame_done;

  assign rx_s = rx_sync_q;

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clock       (clock),
    .reset       (reset),
    .sample_tick (sample_tick),
    .restart     (restart),
    .mid_pulse   (mid_pulse),
    .bit_pulse   (bit_pulse)
  );

  // Receiver FSM and shift register.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    par_flag_d  = par_flag_q;
    frame_acc_d = frame_acc_q;
    restart     = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        // Timer is held at 0 so the start-bit count begins on the detect tick.
        restart = 1'b1;
        if (sample_tick && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (mid_pulse) begin
          if (rx_s) begin
            state_d = RX_IDLE;  // glitch shorter than half a bit
          end else begin
            state_d     = RX_DATA;
            restart     = 1'b1;
            bit_cnt_d   = '0;
            par_flag_d  = 1'b0;
            frame_acc_d = 1'b0;
          end
        end
      end
      RX_DATA: begin
        if (bit_pulse) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (bit_pulse) begin
          par_flag_d = parity_error(^shreg_q, rx_s, PARITY);
          state_d    = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_pulse) begin
          frame_acc_d = frame_acc_q | ~rx_s;
          if (bit_cnt_q == STOP_LAST) begin
            // Back to idle on the last stop sample so a start bit that
            // follows immediately is caught on the next tick.
            state_d    = RX_IDLE;
            frame_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // One-entry output buffer.
  always_comb begin
    data_d        = data_q;
    data_valid_d  = data_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overrun_err_d = 1'b0;
    if (frame_done) begin
      if (!data_valid_q || data_ready) begin
        data_d        = shreg_q;
        parity_err_d  = par_flag_q;
        framing_err_d = frame_acc_d;
        data_valid_d  = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      state_q       <= RX_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      par_flag_q    <= 1'b0;
      frame_acc_q   <= 1'b0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      par_flag_q    <= par_flag_d;
      frame_acc_q   <= frame_acc_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != RX_IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Three receivers side by side: A = 8N1, B = 8E1, C = 7N2 with a tick every
// third clock. Frames are driven on the rx lines a whole bit period at a time;
// expected words/flags come from a word-level model and are queued per
// receiver, then compared whenever a receiver hands a word over.
// -----------------------------------------------------------------------------
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic tick_a, tick_c;
  logic rx_a, rx_b, rx_c;
  logic ready_a, ready_b, ready_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;
  rx_state_t st_a, st_b, st_c;

  uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset(reset), .sample_tick(tick_a), .rx(rx_a), .data(data_a),
    .data_valid(valid_a), .data_ready(ready_a), .parity_err(perr_a), .framing_err(ferr_a),
    .overrun_err(ovr_a), .busy(busy_a), .state_dbg(st_a));

  uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_b (
    .clock(clock), .reset(reset), .sample_tick(tick_a), .rx(rx_b), .data(data_b),
    .data_valid(valid_b), .data_ready(ready_b), .parity_err(perr_b), .framing_err(ferr_b),
    .overrun_err(ovr_b), .busy(busy_b), .state_dbg(st_b));

  uart_rx_deserializer #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_c (
    .clock(clock), .reset(reset), .sample_tick(tick_c), .rx(rx_c), .data(data_c),
    .data_valid(valid_c), .data_ready(ready_c), .parity_err(perr_c), .framing_err(ferr_c),
    .overrun_err(ovr_c), .busy(busy_c), .state_dbg(st_c));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tcnt = 0;
  int pulse_at = -1;
  bit rand_rdy = 1'b0;
  int vcnt_a = 0;
  int ov_a = 0, ov_b = 0, ov_c = 0;

  // {framing_err, parity_err, data padded to 9 bits}
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];
  logic [10:0] exp_c[$];

  typedef struct {
    int         dut;
    logic [8:0] din;
    logic       pbit;
    logic [1:0] stops;   // stops[0] = first stop bit level on the line
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [10:0] e);
    case (d)
      0:       exp_a.push_back(e);
      1:       exp_b.push_back(e);
      default: exp_c.push_back(e);
    endcase
  endtask

  task automatic check_pop(input int d, input logic [10:0] got);
    logic [10:0] e;
    int n;
    n = (d == 0) ? exp_a.size() : (d == 1) ? exp_b.size() : exp_c.size();
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL deliver_%0d: got frame %h expected none", d, got);
      return;
    end
    case (d)
      0:       e = exp_a.pop_front();
      1:       e = exp_b.pop_front();
      default: e = exp_c.pop_front();
    endcase
    if (got !== e) begin
      errors++;
      $display("FAIL deliver_%0d: got {ferr,perr,data}=%h expected %h", d, got, e);
    end
  endtask

  // Word-level reference: what the consumer should see for a given frame.
  function automatic logic [10:0] model(input int d, input logic [8:0] din,
                                        input logic pbit, input logic [1:0] stops);
    int nb;
    int ones;
    logic perr;
    logic ferr;
    logic [8:0] dm;
    nb = (d == 2) ? 7 : 8;
    ones = 0;
    perr = 1'b0;
    dm = '0;
    for (int i = 0; i < nb; i++) begin
      dm[i] = din[i];
      ones += int'(din[i]);
    end
    if (d == 1) perr = ((ones + int'(pbit)) % 2) != 0;
    ferr = (d == 2) ? !(stops[0] && stops[1]) : !stops[0];
    return {ferr, perr, dm};
  endfunction

  task automatic monitor_all();
    if (valid_a) vcnt_a++;
    if (ovr_a) ov_a++;
    if (ovr_b) ov_b++;
    if (ovr_c) ov_c++;
    if (valid_a && ready_a) check_pop(0, {ferr_a, perr_a, 1'b0, data_a});
    if (valid_b && ready_b) check_pop(1, {ferr_b, perr_b, 1'b0, data_b});
    if (valid_c && ready_c) check_pop(2, {ferr_c, perr_c, 2'b00, data_c});
  endtask

  // ---------------- drivers ----------------
  // One clock: outputs observed on the falling edge, inputs changed 1ns
  // after the rising edge.
  task automatic step();
    @(negedge clock);
    monitor_all();
    @(posedge clock);
    #1;
    cyc++;
    tcnt = (tcnt == 2) ? 0 : tcnt + 1;
    tick_c = (tcnt == 0);
    if (pulse_at >= 0) ready_a = (cyc == pulse_at);
    if (rand_rdy) begin
      ready_a = 1'($urandom_range(0, 1));
      ready_b = 1'($urandom_range(0, 1));
      ready_c = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 2) ? 48 : 16;
  endfunction

  task automatic drive_bit(input int d, input logic v, input int clocks);
    case (d)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
    repeat (clocks) step();
  endtask

  task automatic send_frame(input int d, input logic [8:0] din, input logic pbit,
                            input logic [1:0] stops);
    int nb;
    nb = (d == 2) ? 7 : 8;
    drive_bit(d, 1'b0, cpb(d));
    for (int i = 0; i < nb; i++) drive_bit(d, din[i], cpb(d));
    if (d == 1) drive_bit(d, pbit, cpb(d));
    drive_bit(d, stops[0], cpb(d));
    if (d == 2) drive_bit(d, stops[1], cpb(d));
  endtask

  task automatic gap(input int d);
    drive_bit(d, 1'b1, cpb(d));
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[8];
    int ov0;
    int k;
    logic [8:0] rd;
    logic rp;
    logic [1:0] rs;

    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0};
    vecs[2] = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
    vecs[3] = '{1, 9'h081, 1'b1, 2'b10, 9'h081, 1'b1, 1'b1};
    vecs[4] = '{2, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0};
    vecs[5] = '{2, 9'h033, 1'b0, 2'b01, 9'h033, 1'b0, 1'b1};
    vecs[6] = '{2, 9'h07F, 1'b0, 2'b10, 9'h07F, 1'b0, 1'b1};
    vecs[7] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};

    tick_a = 1'b1;
    tick_c = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;

    // reset state
    repeat (3) step();
    chk("reset_a", {19'd0, data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a}, 32'd0);
    chk("reset_b", {19'd0, data_b, valid_b, perr_b, ferr_b, ovr_b, busy_b}, 32'd0);
    chk("reset_c", {20'd0, data_c, valid_c, perr_c, ferr_c, ovr_c, busy_c}, 32'd0);
    chk("reset_state_a", 32'(st_a), 32'(RX_IDLE));
    reset = 1'b0;
    repeat (4) step();

    // table vectors
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].dut, {vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].exp_data});
      send_frame(vecs[i].dut, vecs[i].din, vecs[i].pbit, vecs[i].stops);
      gap(vecs[i].dut);
    end
    repeat (4) step();
    chk("valid_one_cycle_each", 32'(vcnt_a), 32'd2);

    // framing error then back-to-back frame
    push_exp(0, {1'b1, 1'b0, 9'h03C});
    push_exp(0, {1'b0, 1'b0, 9'h055});
    send_frame(0, 9'h03C, 1'b0, 2'b10);
    send_frame(0, 9'h055, 1'b0, 2'b11);
    gap(0);

    // start glitch: low 4 ticks, then high
    rx_a = 1'b0;
    repeat (4) step();
    rx_a = 1'b1;
    step();
    chk("glitch_busy", 32'(busy_a), 32'd1);
    chk("glitch_state", 32'(st_a), 32'(RX_START));
    repeat (7) step();
    chk("glitch_idle", 32'(busy_a), 32'd0);
    repeat (40) step();
    chk("glitch_no_valid", 32'(valid_a), 32'd0);

    // overrun: consumer stalled across two frames
    ready_a = 1'b0;
    ov0 = ov_a;
    push_exp(0, {2'b00, 9'h011});
    send_frame(0, 9'h011, 1'b0, 2'b11);
    gap(0);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    gap(0);
    chk("overrun_pulse_count", 32'(ov_a - ov0), 32'd1);
    chk("overrun_keeps_old", {23'd0, valid_a, data_a}, {23'd0, 1'b1, 8'h11});
    ready_a = 1'b1;
    step();
    chk("overrun_drained", 32'(valid_a), 32'd0);

    // ready pulsed exactly on the completion cycle of the second frame:
    // 2 sync clocks + half bit + 8 data bits + stop = 154 clocks after the
    // start bit goes onto the line.
    ready_a = 1'b0;
    ov0 = ov_a;
    push_exp(0, {2'b00, 9'h011});
    send_frame(0, 9'h011, 1'b0, 2'b11);
    gap(0);
    push_exp(0, {2'b00, 9'h022});
    pulse_at = cyc + 154;
    send_frame(0, 9'h022, 1'b0, 2'b11);
    pulse_at = -1;
    gap(0);
    chk("pulse_no_overrun", 32'(ov_a - ov0), 32'd0);
    chk("pulse_new_word", {23'd0, valid_a, data_a}, {23'd0, 1'b1, 8'h22});
    ready_a = 1'b1;
    step();

    // randomized frames against the model
    rand_rdy = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ov0 = (d == 0) ? ov_a : (d == 1) ? ov_b : ov_c;
      for (int n = 0; n < 6; n++) begin
        rd = 9'($urandom_range(0, 511));
        rp = 1'($urandom_range(0, 1));
        rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        push_exp(d, model(d, rd, rp, rs));
        send_frame(d, rd, rp, rs);
        gap(d);
      end
      k = (d == 0) ? ov_a : (d == 1) ? ov_b : ov_c;
      chk("random_no_overrun", 32'(k - ov0), 32'd0);
    end
    rand_rdy = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (10) step();

    // asynchronous reset in the middle of a 0xFF frame
    rx_a = 1'b0;
    repeat (16) step();
    rx_a = 1'b1;
    repeat (40) step();
    chk("mid_frame_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    step();
    chk("reset_mid_outputs", {19'd0, data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a}, 32'd0);
    step();
    reset = 1'b0;
    gap(0);
    push_exp(0, {2'b00, 9'h081});
    send_frame(0, 9'h081, 1'b0, 2'b11);
    gap(0);
    repeat (10) step();

    chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_b.size()), 32'd0);
    chk("queue_c_empty", 32'(exp_c.size()), 32'd0);
    chk("final_idle", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
    chk("final_state_c", 32'(st_c), 32'(RX_IDLE));
    chk("final_state_b", 32'(st_b), 32'(RX_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
